// File: rtl/param_rd_ctrl.sv
// param_rd_ctrl: reads the conv-layer parameter ROM bank one kernel at a time.
// For each kernel it issues KERNEL_COLS weight addresses and then waits for
// the ROM pipeline to drain. It then holds kernel_rdy until the conv engine
// pulses kernel_done. w_col_vld and w_col_idx follow the address issue strobe,
// delayed by ROM_LAT cycles, so they line up with the ROM output data.
// Optional feature macro: PARAM_TIMEOUT_EN adds a WAIT watchdog that drives err.
module param_rd_ctrl #(
  parameter int KERNEL_NUM  = 6,
  parameter int KERNEL_COLS = 5,
  parameter int BASE_ADDR   = 0,
  parameter int ROM_LAT     = 1,
  parameter int TIMEOUT     = 4096
) (
  input  logic       sclk,
  input  logic       s_rst,
  input  logic       start,
  input  logic       kernel_done,
  output logic [7:0] param_rd_addr,
  output logic [4:0] conv_cnt,
  output logic       w_col_vld,
  output logic [2:0] w_col_idx,
  output logic       bias_vld,
  output logic       kernel_rdy,
  output logic       busy,
  output logic       layer_done,
  output logic       err
);

  typedef enum logic [2:0] {
    S_IDLE,
    S_LOAD,
    S_DRAIN,
    S_WAIT,
    S_DONE
  } state_t;

  localparam logic [7:0] BASE_A     = 8'(BASE_ADDR);
  localparam logic [4:0] LAST_K     = 5'(KERNEL_NUM - 1);
  localparam logic [2:0] LAST_COL   = 3'(KERNEL_COLS - 1);
  localparam logic [1:0] LAST_DRAIN = 2'(ROM_LAT - 1);

  state_t     state;
  logic [2:0] col;
  logic [1:0] drain_cnt;
  logic       rd_en;

  // Latency pipe: stage ROM_LAT-1 lines up with the ROM output data.
  logic [ROM_LAT-1:0]      vld_pipe;
  logic [ROM_LAT-1:0][2:0] idx_pipe;

`ifdef PARAM_TIMEOUT_EN
  localparam logic [15:0] TO_LAST = 16'(TIMEOUT - 1);
  logic [15:0] wait_cnt;
`endif

  // Main sequencer: state, address, kernel/column counters and status flags.
  // NOTE: every register here uses non-blocking assignment, so each branch
  // reads the pre-edge values. col, param_rd_addr and rd_en therefore all
  // describe the same issue cycle.
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      state         <= S_IDLE;
      param_rd_addr <= '0;
      conv_cnt      <= '0;
      col           <= '0;
      drain_cnt     <= '0;
      rd_en         <= 1'b0;
      kernel_rdy    <= 1'b0;
      busy          <= 1'b0;
      layer_done    <= 1'b0;
`ifdef PARAM_TIMEOUT_EN
      wait_cnt      <= '0;
      err           <= 1'b0;
`endif
    end else begin
      layer_done <= 1'b0;
      case (state)
        S_IDLE: begin
          if (start) begin
            state         <= S_LOAD;
            param_rd_addr <= BASE_A;
            conv_cnt      <= '0;
            col           <= '0;
            rd_en         <= 1'b1;
            busy          <= 1'b1;
`ifdef PARAM_TIMEOUT_EN
            err           <= 1'b0;
`endif
          end
        end
        S_LOAD: begin
          if (col == LAST_COL) begin
            state     <= S_DRAIN;
            rd_en     <= 1'b0;
            drain_cnt <= '0;
          end else begin
            col           <= col + 3'd1;
            param_rd_addr <= param_rd_addr + 8'd1;
          end
        end
        S_DRAIN: begin
          if (drain_cnt == LAST_DRAIN) begin
            state      <= S_WAIT;
            kernel_rdy <= 1'b1;
`ifdef PARAM_TIMEOUT_EN
            wait_cnt   <= '0;
`endif
          end else begin
            drain_cnt <= drain_cnt + 2'd1;
          end
        end
        S_WAIT: begin
          if (kernel_done) begin
            kernel_rdy <= 1'b0;
            if (conv_cnt == LAST_K) begin
              state      <= S_DONE;
              layer_done <= 1'b1;
            end else begin
              // Kernels are stored back to back, so the next kernel starts
              // one address past the last column of this one.
              state         <= S_LOAD;
              conv_cnt      <= conv_cnt + 5'd1;
              col           <= '0;
              param_rd_addr <= param_rd_addr + 8'd1;
              rd_en         <= 1'b1;
            end
          end
`ifdef PARAM_TIMEOUT_EN
          else if (wait_cnt == TO_LAST) begin
            state      <= S_IDLE;
            err        <= 1'b1;
            kernel_rdy <= 1'b0;
            busy       <= 1'b0;
            conv_cnt   <= '0;
          end else begin
            wait_cnt <= wait_cnt + 16'd1;
          end
`endif
        end
        S_DONE: begin
          state    <= S_IDLE;
          busy     <= 1'b0;
          conv_cnt <= '0;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  // Delay the issue strobe and column index by ROM_LAT cycles.
  // NOTE: the pipe is cleared on reset even though it only holds flags. A
  // stale valid left over from an aborted read must not surface after reset.
  always_ff @(posedge sclk) begin
    if (s_rst) begin
      vld_pipe <= '0;
      idx_pipe <= '0;
    end else begin
      vld_pipe[0] <= rd_en;
      idx_pipe[0] <= col;
      for (int i = 1; i < ROM_LAT; i++) begin
        vld_pipe[i] <= vld_pipe[i-1];
        idx_pipe[i] <= idx_pipe[i-1];
      end
    end
  end

  assign w_col_vld = vld_pipe[ROM_LAT-1];
  assign w_col_idx = idx_pipe[ROM_LAT-1];
  // The bias word is read once per kernel, together with column 0.
  assign bias_vld  = w_col_vld && (w_col_idx == 3'd0);

`ifndef PARAM_TIMEOUT_EN
  assign err = 1'b0;
`endif

endmodule
